// File: rtl/apb_pkg.sv
// Shared types and constants for the APB demultiplexer family.
// The response struct is sized for the default 32-bit data path.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  localparam int DEF_TIMEOUT_CYCLES = 32;
  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_STRB_WIDTH     = DEF_DATA_WIDTH / 8;

  localparam logic [DEF_STRB_WIDTH-1:0] PSTRB_READ = '0;

  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] rdata;
    logic                      slverr;
  } apb_resp_t;

  localparam apb_resp_t RESP_NONE      = '{rdata: '0, slverr: 1'b0};
  localparam apb_resp_t RESP_LOCAL_ERR = '{rdata: '0, slverr: 1'b1};

endpackage

// File: rtl/apb_demux_decode.sv
// Address decoder: the top SEL_BITS of the address pick the completer index;
// hit is low when the index is beyond the populated completers.
module apb_demux_decode #(
  parameter int ADDR_WIDTH = 32,
  parameter int SEL_BITS   = 4,
  parameter int NUM_SLAVES = 9
) (
  input  logic [ADDR_WIDTH-1:0] paddr,
  output logic [SEL_BITS-1:0]   idx,
  output logic                  hit
);

  // Low address bits only matter to the region-mapped variant.
  logic unused_low_bits;
  assign unused_low_bits = ^paddr[ADDR_WIDTH-SEL_BITS-1:0];

  assign idx = paddr[ADDR_WIDTH-1 -: SEL_BITS];
  assign hit = ({{(32-SEL_BITS){1'b0}}, idx} < 32'(NUM_SLAVES));

endmodule

// File: rtl/apb_demux_top.sv
// 1-to-N APB4 bridge: latches an upstream request, replays it as a clean
// SETUP/ACCESS sequence on one completer and returns a registered response.
module apb_demux_top
  import apb_pkg::*;
#(
  parameter int NUM_APB_SLAVES = 9,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int APB_STRB_WIDTH = APB_DATA_WIDTH / 8,
  parameter int SEL_BITS       = 4,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                                          PCLK,
  input  logic                                          PRESETn,
  input  logic                                          PSEL_s,
  input  logic                                          PENABLE_s,
  input  logic                                          PWRITE_s,
  input  logic [APB_ADDR_WIDTH-1:0]                     PADDR_s,
  input  logic [APB_DATA_WIDTH-1:0]                     PWDATA_s,
  input  logic [APB_STRB_WIDTH-1:0]                     PSTRB_s,
  input  logic [2:0]                                    PPROT_s,
  output logic [APB_DATA_WIDTH-1:0]                     PRDATA_s,
  output logic                                          PREADY_s,
  output logic                                          PSLVERR_s,
  output logic [NUM_APB_SLAVES-1:0]                     PSEL_m,
  output logic                                          PENABLE_m,
  output logic                                          PWRITE_m,
  output logic [APB_ADDR_WIDTH-1:0]                     PADDR_m,
  output logic [APB_DATA_WIDTH-1:0]                     PWDATA_m,
  output logic [APB_STRB_WIDTH-1:0]                     PSTRB_m,
  output logic [2:0]                                    PPROT_m,
  input  logic [NUM_APB_SLAVES-1:0][APB_DATA_WIDTH-1:0] PRDATA_m,
  input  logic [NUM_APB_SLAVES-1:0]                     PREADY_m,
  input  logic [NUM_APB_SLAVES-1:0]                     PSLVERR_m
);

  // A zero timeout still needs a one-bit counter to keep the logic well formed.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  apb_state_e                    state_reg;
  logic [CNT_W-1:0]              wait_cnt_reg;
  logic [CNT_W-1:0]              wait_cnt_next;
  logic [NUM_APB_SLAVES-1:0]     psel_m_reg;
  logic                          penable_m_reg;
  logic                          pwrite_m_reg;
  logic [APB_ADDR_WIDTH-1:0]     paddr_m_reg;
  logic [APB_DATA_WIDTH-1:0]     pwdata_m_reg;
  logic [APB_STRB_WIDTH-1:0]     pstrb_m_reg;
  logic [2:0]                    pprot_m_reg;
  logic                          pready_s_reg;
  apb_resp_t                     resp_reg;

  logic [SEL_BITS-1:0]           dec_idx;
  logic                          dec_hit;
  logic [NUM_APB_SLAVES-1:0]     dec_onehot;
  logic [NUM_APB_SLAVES-1:0][APB_DATA_WIDTH-1:0] rdata_gated;
  logic [APB_DATA_WIDTH-1:0]     sel_rdata;
  logic                          sel_ready;
  logic                          sel_slverr;
  logic                          timeout_hit;

  apb_demux_decode #(
    .ADDR_WIDTH (APB_ADDR_WIDTH),
    .SEL_BITS   (SEL_BITS),
    .NUM_SLAVES (NUM_APB_SLAVES)
  ) u_decode (
    .paddr (PADDR_s),
    .idx   (dec_idx),
    .hit   (dec_hit)
  );

  // The registered one-hot select doubles as the response mux control.
  generate
    for (genvar gi = 0; gi < NUM_APB_SLAVES; gi++) begin : g_slave
      assign dec_onehot[gi]  = (dec_idx == SEL_BITS'(gi));
      assign rdata_gated[gi] = psel_m_reg[gi] ? PRDATA_m[gi] : '0;
    end
  endgenerate

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_APB_SLAVES; i++) begin
      sel_rdata = sel_rdata | rdata_gated[i];
    end
  end

  assign sel_ready     = |(PREADY_m & psel_m_reg);
  assign sel_slverr    = |(PSLVERR_m & psel_m_reg);
  assign wait_cnt_next = wait_cnt_reg + CNT_W'(1);
  assign timeout_hit   = (TIMEOUT_CYCLES != 0) && (wait_cnt_next == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_reg     <= IDLE;
      wait_cnt_reg  <= '0;
      psel_m_reg    <= '0;
      penable_m_reg <= 1'b0;
      pwrite_m_reg  <= 1'b0;
      paddr_m_reg   <= '0;
      pwdata_m_reg  <= '0;
      pstrb_m_reg   <= '0;
      pprot_m_reg   <= '0;
      pready_s_reg  <= 1'b0;
      resp_reg      <= RESP_NONE;
    end else begin
      case (state_reg)
        IDLE: begin
          // A request already in its access phase was never seen in setup.
          if (PSEL_s && !PENABLE_s) begin
            paddr_m_reg  <= PADDR_s;
            pwrite_m_reg <= PWRITE_s;
            pwdata_m_reg <= PWDATA_s;
            pstrb_m_reg  <= PWRITE_s ? PSTRB_s : APB_STRB_WIDTH'(PSTRB_READ);
            pprot_m_reg  <= PPROT_s;
            if (dec_hit) begin
              psel_m_reg    <= dec_onehot;
              penable_m_reg <= 1'b0;
              state_reg     <= SETUP;
            end else begin
              resp_reg      <= RESP_LOCAL_ERR;
              pready_s_reg  <= 1'b1;
              state_reg     <= RESP;
            end
          end
        end
        SETUP: begin
          penable_m_reg <= 1'b1;
          wait_cnt_reg  <= '0;
          state_reg     <= ACCESS;
        end
        ACCESS: begin
          if (sel_ready) begin
            resp_reg.rdata  <= pwrite_m_reg ? '0 : DEF_DATA_WIDTH'(sel_rdata);
            resp_reg.slverr <= sel_slverr;
            psel_m_reg      <= '0;
            penable_m_reg   <= 1'b0;
            pready_s_reg    <= 1'b1;
            state_reg       <= RESP;
          end else if (timeout_hit) begin
            resp_reg        <= RESP_LOCAL_ERR;
            psel_m_reg      <= '0;
            penable_m_reg   <= 1'b0;
            pready_s_reg    <= 1'b1;
            state_reg       <= RESP;
          end else begin
            wait_cnt_reg    <= wait_cnt_next;
          end
        end
        RESP: begin
          pready_s_reg <= 1'b0;
          resp_reg     <= RESP_NONE;
          state_reg    <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign PSEL_m    = psel_m_reg;
  assign PENABLE_m = penable_m_reg;
  assign PWRITE_m  = pwrite_m_reg;
  assign PADDR_m   = paddr_m_reg;
  assign PWDATA_m  = pwdata_m_reg;
  assign PSTRB_m   = pstrb_m_reg;
  assign PPROT_m   = pprot_m_reg;
  assign PREADY_s  = pready_s_reg;
  assign PRDATA_s  = APB_DATA_WIDTH'(resp_reg.rdata);
  assign PSLVERR_s = resp_reg.slverr;

endmodule

// File: tb/tb_apb_demux_top.sv
// Bench for apb_demux_top: directed cases plus randomized transfers checked
// against a latency/response model derived from the decode and timeout rules.
module tb_apb_demux_top;

  localparam int N   = 9;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = 4;
  localparam int TMO = 32;

  logic              PCLK;
  logic              PRESETn;
  logic              PSEL_s, PENABLE_s, PWRITE_s;
  logic [AW-1:0]     PADDR_s;
  logic [DW-1:0]     PWDATA_s;
  logic [SW-1:0]     PSTRB_s;
  logic [2:0]        PPROT_s;
  logic [DW-1:0]     PRDATA_s;
  logic              PREADY_s, PSLVERR_s;
  logic [N-1:0]      PSEL_m;
  logic              PENABLE_m, PWRITE_m;
  logic [AW-1:0]     PADDR_m;
  logic [DW-1:0]     PWDATA_m;
  logic [SW-1:0]     PSTRB_m;
  logic [2:0]        PPROT_m;
  logic [N-1:0][DW-1:0] PRDATA_m;
  logic [N-1:0]      PREADY_m, PSLVERR_m;

  int n_checks = 0;
  int n_errors = 0;

  int wait_cfg = 0;
  bit hang_cfg = 1'b0;
  bit err_cfg  = 1'b0;
  int acc_cnt  = 0;

  apb_demux_top #(
    .NUM_APB_SLAVES (N),
    .APB_ADDR_WIDTH (AW),
    .APB_DATA_WIDTH (DW),
    .APB_STRB_WIDTH (SW),
    .SEL_BITS       (4),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .PSEL_s    (PSEL_s),
    .PENABLE_s (PENABLE_s),
    .PWRITE_s  (PWRITE_s),
    .PADDR_s   (PADDR_s),
    .PWDATA_s  (PWDATA_s),
    .PSTRB_s   (PSTRB_s),
    .PPROT_s   (PPROT_s),
    .PRDATA_s  (PRDATA_s),
    .PREADY_s  (PREADY_s),
    .PSLVERR_s (PSLVERR_s),
    .PSEL_m    (PSEL_m),
    .PENABLE_m (PENABLE_m),
    .PWRITE_m  (PWRITE_m),
    .PADDR_m   (PADDR_m),
    .PWDATA_m  (PWDATA_m),
    .PSTRB_m   (PSTRB_m),
    .PPROT_m   (PPROT_m),
    .PRDATA_m  (PRDATA_m),
    .PREADY_m  (PREADY_m),
    .PSLVERR_m (PSLVERR_m)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Completer model: the selected slave answers after wait_cfg access cycles;
  // unselected slaves drive junk so a bad response mux shows up.
  always @(posedge PCLK) begin
    if ((|PSEL_m) && PENABLE_m) acc_cnt <= acc_cnt + 1;
    else                        acc_cnt <= 0;
  end

  always_comb begin
    PREADY_m  = '1;
    PSLVERR_m = '1;
    PRDATA_m  = '0;
    for (int i = 0; i < N; i++) begin
      if (PSEL_m[i]) begin
        PREADY_m[i]  = PENABLE_m && !hang_cfg && (acc_cnt >= wait_cfg);
        PSLVERR_m[i] = PREADY_m[i] && err_cfg;
        PRDATA_m[i]  = {8'hDE, PADDR_m[23:0]};
      end else begin
        PRDATA_m[i]  = {8'h5A, 4'(i), 20'hBEEF0};
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".psel_m"},    64'(PSEL_m),    64'd0);
    check_eq({tag, ".penable_m"}, 64'(PENABLE_m), 64'd0);
    check_eq({tag, ".pwrite_m"},  64'(PWRITE_m),  64'd0);
    check_eq({tag, ".paddr_m"},   64'(PADDR_m),   64'd0);
    check_eq({tag, ".pwdata_m"},  64'(PWDATA_m),  64'd0);
    check_eq({tag, ".pstrb_m"},   64'(PSTRB_m),   64'd0);
    check_eq({tag, ".pprot_m"},   64'(PPROT_m),   64'd0);
    check_eq({tag, ".pready_s"},  64'(PREADY_s),  64'd0);
    check_eq({tag, ".prdata_s"},  64'(PRDATA_s),  64'd0);
    check_eq({tag, ".pslverr_s"}, 64'(PSLVERR_s), 64'd0);
  endtask

  // Reference: lat = clock edges after the setup edge until PREADY_s is seen.
  function automatic void model(input logic [31:0] addr, input bit write, input int wait_c,
                                input bit hang_c, input bit err_c, output bit hit,
                                output int lat, output logic [31:0] rdata, output bit slverr);
    int idx;
    idx = int'(addr[31:28]);
    hit = (idx < N);
    if (!hit) begin
      lat = 0; rdata = '0; slverr = 1'b1;
    end else if (hang_c || wait_c >= TMO) begin
      lat = 1 + TMO; rdata = '0; slverr = 1'b1;
    end else begin
      lat = 2 + wait_c;
      rdata = write ? 32'h0 : {8'hDE, addr[23:0]};
      slverr = err_c;
    end
  endfunction

  // Starts and ends on a falling edge so calls chain back-to-back.
  task automatic xfer(input string name, input logic [31:0] addr, input bit write,
                      input logic [31:0] wdata, input logic [3:0] strb, input logic [2:0] prot,
                      input int wait_c, input bit hang_c, input bit err_c, input bit drop_psel);
    bit hit, exp_err, got;
    int lat, k;
    logic [31:0] exp_rdata;
    logic [N-1:0] exp_sel;
    model(addr, write, wait_c, hang_c, err_c, hit, lat, exp_rdata, exp_err);
    exp_sel = '0;
    if (hit) exp_sel = N'(1) << int'(addr[31:28]);
    wait_cfg = wait_c; hang_cfg = hang_c; err_cfg = err_c;
    PSEL_s = 1'b1; PENABLE_s = 1'b0; PWRITE_s = write; PADDR_s = addr;
    PWDATA_s = wdata; PSTRB_s = strb; PPROT_s = prot;
    k = 0; got = 1'b0;
    while (!got && k < 60) begin
      @(negedge PCLK);
      k++;
      if (k == 1) begin
        if (drop_psel) PSEL_s = 1'b0;
        else           PENABLE_s = 1'b1;
      end
      if (PREADY_s) begin
        got = 1'b1;
      end else if (hit) begin
        if (k == 1) begin
          check_eq({name, ".setup_psel"},    64'(PSEL_m),    64'(exp_sel));
          check_eq({name, ".setup_penable"}, 64'(PENABLE_m), 64'd0);
          check_eq({name, ".paddr_m"},       64'(PADDR_m),   64'(addr));
          check_eq({name, ".pwrite_m"},      64'(PWRITE_m),  64'(write));
          check_eq({name, ".pwdata_m"},      64'(PWDATA_m),  64'(wdata));
          check_eq({name, ".pstrb_m"},       64'(PSTRB_m),   write ? 64'(strb) : 64'd0);
          check_eq({name, ".pprot_m"},       64'(PPROT_m),   64'(prot));
        end
        if (k == 2) begin
          check_eq({name, ".access_psel"},    64'(PSEL_m),    64'(exp_sel));
          check_eq({name, ".access_penable"}, 64'(PENABLE_m), 64'd1);
        end
        if (k == lat && k > 2) begin
          check_eq({name, ".last_psel"},  64'(PSEL_m),  64'(exp_sel));
          check_eq({name, ".last_paddr"}, 64'(PADDR_m), 64'(addr));
        end
      end
    end
    check_eq({name, ".latency"},   64'(k),         64'(lat + 1));
    check_eq({name, ".prdata_s"},  64'(PRDATA_s),  64'(exp_rdata));
    check_eq({name, ".pslverr_s"}, 64'(PSLVERR_s), 64'(exp_err));
    check_eq({name, ".resp_psel"}, 64'(PSEL_m),    64'd0);
    check_eq({name, ".resp_pen"},  64'(PENABLE_m), 64'd0);
    $display("xfer %-10s %s addr=0x%08h wait=%0d hang=%0d -> cycles=%0d prdata=0x%08h pslverr=%0d",
             name, write ? "WR" : "RD", addr, wait_c, hang_c, k, PRDATA_s, PSLVERR_s);
    @(negedge PCLK);
    check_eq({name, ".pready_drop"}, 64'(PREADY_s),  64'd0);
    check_eq({name, ".prdata_clr"},  64'(PRDATA_s),  64'd0);
    check_eq({name, ".slverr_clr"},  64'(PSLVERR_s), 64'd0);
    PSEL_s = 1'b0; PENABLE_s = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] r, addr, wdata;
    logic [3:0]  nib;
    PRESETn = 1'b0;
    PSEL_s = 1'b0; PENABLE_s = 1'b0; PWRITE_s = 1'b0;
    PADDR_s = '0; PWDATA_s = '0; PSTRB_s = '0; PPROT_s = '0;
    repeat (3) @(negedge PCLK);
    check_all_zero("reset");
    PRESETn = 1'b1;
    @(negedge PCLK);

    xfer("wr_s1",   32'h1000_0000, 1'b1, 32'hAAAA_AAAA, 4'hF, 3'd2, 0, 1'b0, 1'b0, 1'b0);
    xfer("rd_s4",   32'h4000_0000, 1'b0, 32'h1234_5678, 4'hF, 3'd0, 0, 1'b0, 1'b0, 1'b0);
    xfer("rd_s5",   32'h5000_0000, 1'b0, 32'h0,         4'h3, 3'd1, 0, 1'b0, 1'b0, 1'b0);
    xfer("rd_s8",   32'h8000_0000, 1'b0, 32'h0,         4'h0, 3'd0, 0, 1'b0, 1'b0, 1'b0);
    xfer("rd_miss", 32'hC000_0000, 1'b0, 32'h0,         4'h0, 3'd0, 0, 1'b0, 1'b0, 1'b0);
    xfer("rd_tmo",  32'h2000_0000, 1'b0, 32'h0,         4'h0, 3'd0, 0, 1'b1, 1'b0, 1'b0);
    xfer("rd_w5",   32'h2000_0004, 1'b0, 32'h0,         4'h0, 3'd0, 5, 1'b0, 1'b0, 1'b0);
    xfer("rd_w31",  32'h7000_0100, 1'b0, 32'h0,         4'h0, 3'd0, 31, 1'b0, 1'b0, 1'b0);
    xfer("wr_err",  32'h3000_0010, 1'b1, 32'h5555_0000, 4'hC, 3'd3, 0, 1'b0, 1'b1, 1'b0);
    xfer("rd_b2b",  32'h3000_0014, 1'b0, 32'h0,         4'h0, 3'd0, 0, 1'b0, 1'b0, 1'b0);
    xfer("rd_drop", 32'h0012_3456, 1'b0, 32'h0,         4'h0, 3'd0, 2, 1'b0, 1'b0, 1'b1);

    // A request already in its access phase must not start a transfer.
    PSEL_s = 1'b1; PENABLE_s = 1'b1; PADDR_s = 32'h1000_0000; PWRITE_s = 1'b0;
    repeat (3) begin
      @(negedge PCLK);
      check_eq("illegal.psel_m",   64'(PSEL_m),   64'd0);
      check_eq("illegal.pready_s", 64'(PREADY_s), 64'd0);
    end
    PSEL_s = 1'b0; PENABLE_s = 1'b0;
    @(negedge PCLK);

    // Reset in the middle of an access phase drops the transfer.
    wait_cfg = 20; hang_cfg = 1'b0; err_cfg = 1'b0;
    PSEL_s = 1'b1; PENABLE_s = 1'b0; PWRITE_s = 1'b0; PADDR_s = 32'h6000_0000;
    PSTRB_s = 4'hF; PWDATA_s = 32'h0; PPROT_s = 3'd1;
    @(negedge PCLK);
    PENABLE_s = 1'b1;
    repeat (3) @(negedge PCLK);
    check_eq("midrst.psel_before", 64'(PSEL_m),    64'h40);
    check_eq("midrst.pen_before",  64'(PENABLE_m), 64'd1);
    #2 PRESETn = 1'b0;
    #1 check_all_zero("midrst");
    PSEL_s = 1'b0; PENABLE_s = 1'b0;
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
    xfer("rd_s6", 32'h6000_0000, 1'b0, 32'h0, 4'h0, 3'd0, 0, 1'b0, 1'b0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      int gap, wc;
      bit wr, hg, er, dp;
      r = $urandom();
      nib = 4'($urandom_range(0, 15));
      addr = {nib, r[27:0]};
      wdata = $urandom();
      wr = 1'($urandom_range(0, 1));
      hg = ($urandom_range(0, 7) == 0);
      er = ($urandom_range(0, 3) == 0);
      dp = ($urandom_range(0, 5) == 0);
      wc = $urandom_range(0, 6);
      xfer($sformatf("rnd%0d", t), addr, wr, wdata, 4'($urandom_range(0, 15)),
           3'($urandom_range(0, 7)), wc, hg, er, dp);
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge PCLK);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/apb_demux_top.md
Name: apb_demux_top

Overview:
- 1-to-N APB4 demultiplexer (address-decoding bridge); the downstream counterpart of apb_mux_top.
- One upstream requester port connects to apb_mux_top's slave-side bus. Transfers are routed to one of NUM_APB_SLAVES completers, selected by the top address bits.
- Fully registered FSM: latches each request, drives a clean SETUP/ACCESS sequence downstream, returns a registered response.
- Generates local errors for decode misses and completer timeouts.

Parameters:
- NUM_APB_SLAVES, 9, number of downstream completers (2..16).
- APB_ADDR_WIDTH, 32, address width.
- APB_DATA_WIDTH, 32, data width.
- APB_STRB_WIDTH, APB_DATA_WIDTH/8, strobe width.
- SEL_BITS, 4, slave index = PADDR_s[APB_ADDR_WIDTH-1 -: SEL_BITS].
- TIMEOUT_CYCLES, 32, maximum ACCESS wait cycles; 0 disables the timeout.

Ports:
- PCLK  in  1  clock.
- PRESETn  in  1  asynchronous active-low reset.
- PSEL_s, PENABLE_s, PWRITE_s  in  1 each  upstream control.
- PADDR_s  in  APB_ADDR_WIDTH  upstream address.
- PWDATA_s  in  APB_DATA_WIDTH  upstream write data.
- PSTRB_s  in  APB_STRB_WIDTH  upstream write strobes.
- PPROT_s  in  3  upstream protection.
- PRDATA_s  out  APB_DATA_WIDTH  upstream read data.
- PREADY_s, PSLVERR_s  out  1 each  upstream response.
- PSEL_m  out  [NUM_APB_SLAVES] x 1  per-slave select.
- PENABLE_m, PWRITE_m  out  1 each  shared downstream control.
- PADDR_m  out  APB_ADDR_WIDTH  shared downstream address.
- PWDATA_m  out  APB_DATA_WIDTH  shared downstream write data.
- PSTRB_m  out  APB_STRB_WIDTH  shared downstream strobes.
- PPROT_m  out  3  shared downstream protection.
- PRDATA_m  in  [NUM_APB_SLAVES] x APB_DATA_WIDTH  per-slave read data.
- PREADY_m, PSLVERR_m  in  [NUM_APB_SLAVES] x 1  per-slave response.

Behaviour:
- Single clock PCLK; PRESETn is asynchronous, active-low. All outputs are registered.
- Reset value of every output is 0. FSM goes to IDLE immediately on reset, including mid-transfer; any downstream transfer in progress is dropped.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE, on PSEL_s=1 & PENABLE_s=0 sampled at edge E0:
  - Latch addr, write, wdata, strb, prot; compute idx.
  - idx < NUM_APB_SLAVES -> SETUP: after E0, PSEL_m[idx]=1, PENABLE_m=0.
  - idx >= NUM_APB_SLAVES -> RESP with PSLVERR_s=1, PRDATA_s=0; no PSEL_m is asserted.
- IDLE ignores PSEL_s=1 & PENABLE_s=1 (illegal; no transfer is started).
- SETUP -> ACCESS unconditionally at E1: PENABLE_m=1 after E1.
- ACCESS, each edge:
  - If PREADY_m[idx]=1: capture PRDATA_m[idx] (0 for writes) and PSLVERR_m[idx]; deassert PSEL_m/PENABLE_m; go to RESP.
  - Else increment the wait counter. If the counter reaches TIMEOUT_CYCLES, deassert PSEL_m/PENABLE_m and go to RESP with PSLVERR_s=1, PRDATA_s=0.
- RESP: PREADY_s=1 for exactly one cycle with PRDATA_s/PSLVERR_s valid, then IDLE. All three outputs return to 0 in IDLE.
- Zero-wait latency: PREADY_m high at E2 -> PREADY_s high in the cycle after E2. Decode error: PREADY_s high in the cycle after E0.
- Back-to-back: a new upstream setup in the cycle after PREADY_s is accepted at the next IDLE edge; no dead cycle beyond IDLE.
- Downstream bus values:
  - PADDR_m, PWRITE_m, PWDATA_m, PPROT_m are broadcast from the latched values and held stable from SETUP through ACCESS.
  - PSTRB_m = latched strobe on writes, 0 on reads.
- Upstream inputs are not re-sampled after E0. If PSEL_s drops mid-transfer, the downstream transfer still completes and the PREADY_s pulse is still issued.
- Exactly one PSEL_m bit is high at any time, or none.
- Wait counter is clog2(TIMEOUT_CYCLES+1) bits and is cleared on entry to ACCESS. With TIMEOUT_CYCLES=0, ACCESS waits indefinitely.

Decomposition:
- apb_pkg holds:
  - state enum typedef (IDLE/SETUP/ACCESS/RESP);
  - DEF_TIMEOUT_CYCLES constant;
  - PSTRB_READ constant ('0);
  - response struct {rdata, slverr}.
- Sub-module apb_demux_decode (combinational): PADDR, SEL_BITS -> idx and hit. It is reused later for a region-mapped variant.

Test Plan:
- Write to slave 1: addr 0x1000_0000, wdata 0xAAAA_AAAA, zero-wait completer -> PSEL_m[1] only; PWDATA_m=0xAAAA_AAAA; PSTRB_m=0xF; PREADY_s one cycle after E2; PSLVERR_s=0.
- Reads to 0x4000_0000, 0x5000_0000, 0x8000_0000 with completer returning {8'hDE, addr[23:0]} -> PSEL_m[4]/[5]/[8] respectively; PRDATA_s=0xDE00_0000 each; PSTRB_m=0.
- Read to 0xC000_0000 (idx 12 >= 9) -> no PSEL_m bit set; PREADY_s=1 and PSLVERR_s=1 in the cycle after E0; PRDATA_s=0.
- Slave 2 holds PREADY_m low -> after 32 ACCESS cycles PSEL_m[2] drops; PREADY_s=1, PSLVERR_s=1, PRDATA_s=0. Repeat with PREADY_m after 5 waits -> normal completion, PSLVERR_s=0.
- Completer returns PSLVERR_m[3]=1 on a write to 0x3000_0010 -> PSLVERR_s=1 alongside PREADY_s; then an immediate back-to-back read to 0x3000_0014 completes with PSLVERR_s=0.
- Assert PRESETn low during ACCESS of a read to slave 6 -> all outputs 0 asynchronously; after release, a new read to 0x6000_0000 returns 0xDE00_0000.
